// File: rtl/systolic_pkg.sv
// systolic_pkg: shared state encoding, element type and stream-length helper
// for systolic_input_feeder and its skew_bank storage.
package systolic_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 16;

    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        LOAD      = 2'd0,
        STREAM    = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Number of cycles a skewed wavefront of a SIZE x SIZE batch occupies.
    function automatic int unsigned stream_len(input int unsigned size);
        return 2 * size - 1;
    endfunction

endpackage

// File: rtl/systolic_input_feeder_skew_bank.sv
// skew_bank: SIZE x SIZE element store. Rows are written one vector at a
// time; the read port returns the diagonally skewed lane set for step t.
module skew_bank
    import systolic_pkg::*;
#(
    parameter int unsigned SIZE       = 3,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned RW         = (SIZE > 1) ? $clog2(SIZE) : 1,
    parameter int unsigned TW         = $clog2(stream_len(SIZE) + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [RW-1:0]         i_row,
    input  logic [DATA_WIDTH-1:0] i_vec  [0:SIZE-1],
    input  logic [TW-1:0]         i_t,
    output logic [DATA_WIDTH-1:0] o_data [0:SIZE-1]
);

    logic [DATA_WIDTH-1:0] r_mem [0:SIZE-1][0:SIZE-1];

    // Capture one vector per write into the addressed row; reset discards the batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < SIZE; r++) begin
                for (int unsigned c = 0; c < SIZE; c++) begin
                    r_mem[r][c] <= '0;
                end
            end
        end else if (i_we) begin
            for (int unsigned c = 0; c < SIZE; c++) begin
                r_mem[i_row][c] <= i_vec[c];
            end
        end
    end

    // Lane i shows row t-i while that row lies inside the batch; a row being
    // written this very cycle is forwarded so the first step never sees stale data.
    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            o_data[i] = '0;
            if ((32'(i_t) >= i) && ((32'(i_t) - i) < SIZE)) begin
                if (i_we && (32'(i_row) == (32'(i_t) - i))) begin
                    o_data[i] = i_vec[i];
                end else begin
                    o_data[i] = r_mem[RW'(32'(i_t) - i)][i];
                end
            end
        end
    end

endmodule

// File: rtl/systolic_input_feeder.sv
// systolic_input_feeder: buffers a batch of SIZE vectors and replays it as
// the skewed wavefront a weight-stationary systolic array expects.
// Optional build macro FEEDER_DOUBLE_BUF_EN adds a second ping-pong bank so
// the next batch can be loaded while the current one streams.
module systolic_input_feeder
    import systolic_pkg::*;
#(
    parameter int unsigned SIZE       = 3,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_vec     [0:SIZE-1],
    output logic [DATA_WIDTH-1:0] array_data [0:SIZE-1],
    output logic                  array_start,
    input  logic                  array_done,
    output logic                  busy
);

    localparam int unsigned LEN = stream_len(SIZE);
    localparam int unsigned TW  = $clog2(LEN + 1);
    localparam int unsigned RW  = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [TW-1:0] T_LAST   = TW'(LEN - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(SIZE - 1);

    state_t                r_state, w_state_nxt;
    logic [TW-1:0]         r_t, w_t_nxt;
    logic [RW-1:0]         r_wr_row;
    logic                  w_xfer, w_batch_done, w_pending, w_enter;
    logic [DATA_WIDTH-1:0] w_skew [0:SIZE-1];
    logic [DATA_WIDTH-1:0] r_data [0:SIZE-1];
    logic                  r_start;

    assign w_xfer       = in_valid & in_ready;
    assign w_batch_done = w_xfer & (r_wr_row == ROW_LAST);

`ifdef FEEDER_DOUBLE_BUF_EN
    logic                  r_wr_bank, r_rd_bank, r_cur_bank, w_rd_sel;
    logic [1:0]            r_full;
    logic [DATA_WIDTH-1:0] w_skew0 [0:SIZE-1];
    logic [DATA_WIDTH-1:0] w_skew1 [0:SIZE-1];

    assign in_ready  = ~r_full[r_wr_bank];
    // A batch finishing this cycle into the next read bank already counts as pending.
    assign w_pending = r_full[r_rd_bank] | (w_batch_done & (r_wr_bank == r_rd_bank));
    assign w_rd_sel  = w_enter ? r_rd_bank : r_cur_bank;

    skew_bank #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .RW(RW), .TW(TW)) u_bank0 (
        .clk(clk), .rst(rst), .i_we(w_xfer & ~r_wr_bank), .i_row(r_wr_row),
        .i_vec(in_vec), .i_t(w_t_nxt), .o_data(w_skew0)
    );

    skew_bank #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .RW(RW), .TW(TW)) u_bank1 (
        .clk(clk), .rst(rst), .i_we(w_xfer & r_wr_bank), .i_row(r_wr_row),
        .i_vec(in_vec), .i_t(w_t_nxt), .o_data(w_skew1)
    );

    // Select the bank being streamed (or about to be) for the skewed read.
    always_comb begin
        for (int unsigned i = 0; i < SIZE; i++) begin
            w_skew[i] = w_rd_sel ? w_skew1[i] : w_skew0[i];
        end
    end

    // Ping-pong bookkeeping: fill on batch completion, free once the stream ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_cur_bank <= 1'b0;
            r_full     <= '0;
        end else begin
            if (w_batch_done) begin
                r_full[r_wr_bank] <= 1'b1;
                r_wr_bank         <= ~r_wr_bank;
            end
            if (w_enter) begin
                r_cur_bank <= r_rd_bank;
                r_rd_bank  <= ~r_rd_bank;
            end
            if ((r_state == STREAM) && (r_t == T_LAST)) begin
                r_full[r_cur_bank] <= 1'b0;
            end
        end
    end
`else
    assign in_ready  = (r_state == LOAD);
    assign w_pending = w_batch_done;

    skew_bank #(.SIZE(SIZE), .DATA_WIDTH(DATA_WIDTH), .RW(RW), .TW(TW)) u_bank (
        .clk(clk), .rst(rst), .i_we(w_xfer), .i_row(r_wr_row),
        .i_vec(in_vec), .i_t(w_t_nxt), .o_data(w_skew)
    );
`endif

    // State and stream-step registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
            r_t     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
        end
    end

    // Next-state and next-step decode; a full batch starts the stream at step 0.
    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = '0;
        w_enter     = 1'b0;
        case (r_state)
            LOAD: begin
                if (w_pending) begin
                    w_state_nxt = STREAM;
                    w_enter     = 1'b1;
                end
            end
            STREAM: begin
                if (r_t == T_LAST) begin
                    w_state_nxt = WAIT_DONE;
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end
            WAIT_DONE: begin
                if (array_done) begin
                    if (w_pending) begin
                        w_state_nxt = STREAM;
                        w_enter     = 1'b1;
                    end else begin
                        w_state_nxt = LOAD;
                    end
                end
            end
            default: w_state_nxt = LOAD;
        endcase
    end

    // Write row pointer, wrapping once per batch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_row <= '0;
        end else if (w_xfer) begin
            r_wr_row <= (r_wr_row == ROW_LAST) ? '0 : r_wr_row + RW'(1);
        end
    end

    // Outputs are registered against the upcoming state so lanes, start and
    // state change on the same edge; lanes are forced to zero outside STREAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_start <= 1'b0;
            for (int unsigned i = 0; i < SIZE; i++) begin
                r_data[i] <= '0;
            end
        end else begin
            r_start <= w_enter;
            for (int unsigned i = 0; i < SIZE; i++) begin
                r_data[i] <= (w_state_nxt == STREAM) ? w_skew[i] : '0;
            end
        end
    end

    assign array_data  = r_data;
    assign array_start = r_start;
    assign busy        = (r_state != LOAD);

endmodule

// File: doc/systolic_input_feeder.md
# systolic_input_feeder

Upstream feeder for the weight-stationary `systolic_array`. It accepts a batch of SIZE input vectors over a valid/ready stream and buffers them. It then drives the array's `input_data` lanes with the diagonally skewed wavefront the array needs, and pulses the array's `start`. It holds off the next batch until the array reports `done`.

## Interface
Parameters:
- SIZE, 3, array dimension; lanes per vector and vectors per batch
- DATA_WIDTH, 16, element width; must match the array

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  upstream vector valid
- in_ready  out  1  feeder can accept a vector this cycle
- in_vec  in  DATA_WIDTH x [0:SIZE-1]  input vector; element i goes to lane i
- array_data  out  DATA_WIDTH x [0:SIZE-1]  registered; connects to array `input_data`
- array_start  out  1  one-cycle pulse; connects to array `start`
- array_done  in  1  array `done`
- busy  out  1  high in STREAM or WAIT_DONE

## Operation
- A transfer occurs when in_valid && in_ready. Vector k of a batch (k = 0..SIZE-1) is written to buffer row k. Write row counter wraps 0..SIZE-1.
- FSM states:
  - LOAD (reset state): in_ready=1. The SIZE-th accepted vector goes to STREAM.
  - STREAM: counter t runs 0..2*SIZE-2. At t = 2*SIZE-2 go to WAIT_DONE.
  - WAIT_DONE: leave on array_done=1. Next state is LOAD, or STREAM if a full bank is pending (double-buffer build only).
- Skew rule: during STREAM step t, array_data[i] = X[t-i][i] when 0 <= t-i <= SIZE-1, else 0.
- array_data is 0 in every state other than STREAM.
- array_start=1 exactly on step t=0 of each STREAM entry.
- In_vec is captured unmodified; no arithmetic is performed. Element width is DATA_WIDTH throughout.
- in_valid while in_ready=0 is held off; no data is lost and no overflow is possible.
- array_done is ignored outside WAIT_DONE. The array's done is high after reset and before its first start.
- Reset mid-operation: the buffer contents are discarded and the FSM returns to LOAD with counters at 0.

## Timing
- Reset values:
  - in_ready=1 (state LOAD)
  - array_data all 0
  - array_start=0
  - busy=0
  - t=0, write row=0
- Latency: the SIZE-th transfer at cycle c gives STREAM step t=0 with array_start=1 at cycle c+1.
- The stream lasts 2*SIZE-1 cycles, c+1 .. c+2*SIZE-1. WAIT_DONE begins at c+2*SIZE.
- The array raises done 3*SIZE cycles after it samples start. The feeder returns to LOAD the cycle after it samples array_done=1.
- in_ready is combinational from state and bank status; it has no dependency on in_valid.

## Configuration
- FEEDER_DOUBLE_BUF_EN defined: two ping-pong buffer banks.
  - in_ready=1 whenever the write bank is not full, including during STREAM and WAIT_DONE.
  - A batch completed while the other bank streams is marked pending.
  - WAIT_DONE with array_done=1 and a bank pending goes directly to STREAM on that bank.
  - If both banks are full, in_ready=0.
  - Bank select toggles on each batch completion (write side) and each STREAM entry (read side).
- Undefined: a single bank. in_ready=0 in STREAM and WAIT_DONE.

## Structure
- Package `systolic_pkg`:
  - state enum {LOAD, STREAM, WAIT_DONE}
  - localparam-style function for stream length 2*SIZE-1
  - the shared DATA_WIDTH vector typedef
- Sub-module `skew_bank`: SIZE x SIZE register bank with a write port (row, vector) and a combinational skewed read port indexed by t. It is instantiated once, or twice under FEEDER_DOUBLE_BUF_EN.

## Test plan
- SIZE=3, push rows {1,2,3}, {4,5,6}, {7,8,9} back-to-back. Lanes [0,1,2] per cycle must be:
  - [1,0,0]
  - [4,2,0]
  - [7,5,3]
  - [0,8,6]
  - [0,0,9]

  array_start must be high only on the first of these.
- Hold array_done low for 20 cycles after the stream. busy stays 1 and in_ready stays 0 (single-bank build). Raising array_done gives in_ready=1 the next cycle.
- Toggle in_valid randomly during LOAD. The captured order and stream are identical to the back-to-back case, and array_start is delayed until the third transfer.
- Assert rst during STREAM step 2. All outputs go to their reset values immediately. A new batch after reset streams correctly, with no residue from the old batch.
- FEEDER_DOUBLE_BUF_EN: push two batches continuously. The second batch is fully accepted during the first stream. The second array_start occurs the cycle after array_done is sampled.
- array_done=1 held high from reset while loading: there is no premature exit and no extra start pulse.
